// File: rtl/inst_aligner.sv
// Fetch-side parcel aligner: buffers 16-bit parcels from aligned fetch words,
// reassembles straddling 32-bit instructions and expands RV32C to RV32I.
module inst_aligner #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            BUF_PARCELS = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic [31:0]           fetch_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_is_c,
  output logic                  inst_illegal
);

  localparam int unsigned CNT_W = $clog2(BUF_PARCELS + 1);
  localparam int unsigned PTR_W = $clog2(BUF_PARCELS);
  localparam int unsigned WRD_W = ADDR_WIDTH - 2;

  logic [15:0]           buf_q [BUF_PARCELS];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [WRD_W-1:0]      exp_word;
  logic                  drop_lo;

  logic [15:0] p0, p1;
  logic        need2, avail, active;
  logic        push_en;
  logic [1:0]  push_n, pop_n;
  logic [31:0] exp_inst;
  logic        exp_ill;
  logic        unused_ok;

  // Circular increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= BUF_PARCELS) s = s - BUF_PARCELS;
    return PTR_W'(s);
  endfunction

  assign unused_ok = ^{fetch_addr[1:0], flush_pc[0]};

  assign p0     = buf_q[rd_ptr];
  assign p1     = buf_q[ptr_add(rd_ptr, 1)];
  assign need2  = (p0[1:0] == 2'b11);
  assign avail  = need2 ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
  assign active = !rst_in && rdy_in && !flush_in;

  assign fetch_ready = active && (count <= CNT_W'(BUF_PARCELS - 2));
  assign inst_valid  = active && avail;
  assign inst_pc     = rst_in ? RESET_PC : head_pc;

  assign push_en = fetch_valid && fetch_ready && (fetch_addr[ADDR_WIDTH-1:2] == exp_word);
  assign push_n  = push_en ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n   = (inst_valid && inst_ready) ? (need2 ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin : out_mux
    inst_out     = '0;
    inst_is_c    = 1'b0;
    inst_illegal = 1'b0;
    if (inst_valid) begin
      if (need2) begin
        inst_out = {p1, p0};
      end else begin
        inst_is_c    = 1'b1;
        inst_illegal = exp_ill;
        inst_out     = exp_ill ? 32'd0 : exp_inst;
      end
    end
  end

  // RV32C to RV32I expansion of the head parcel.
  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [20:0] jimm;
  logic [12:0] bimm;
  logic [2:0]  alu_f3;

  assign c    = p0;
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign jimm = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign bimm = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin : rvc_expand
    exp_inst = '0;
    exp_ill  = 1'b0;
    alu_f3   = 3'b000;
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        if (c[12:5] == 8'd0) exp_ill = 1'b1;
        else exp_inst = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
      end
      5'b00_010: exp_inst = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
      5'b00_110: exp_inst = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000: exp_inst = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'b0010011};
      5'b01_001: exp_inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'b1101111};
      5'b01_010: exp_inst = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'b0010011};
      5'b01_011: begin
        if ({c[12], c[6:2]} == 6'd0) exp_ill = 1'b1;
        else if (rd == 5'd2)
          exp_inst = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
        else
          exp_inst = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00, 2'b01: begin
            if (c[12]) exp_ill = 1'b1;
            else exp_inst = {1'b0, c[10], 5'b0, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
          end
          2'b10: exp_inst = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'b0010011};
          default: begin
            case (c[6:5])
              2'b00:   alu_f3 = 3'b000;
              2'b01:   alu_f3 = 3'b100;
              2'b10:   alu_f3 = 3'b110;
              default: alu_f3 = 3'b111;
            endcase
            if (c[12]) exp_ill = 1'b1;
            else exp_inst = {1'b0, (c[6:5] == 2'b00), 5'b0, rdp, rs1p, alu_f3, rs1p, 7'b0110011};
          end
        endcase
      end
      5'b01_101: exp_inst = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'b1101111};
      5'b01_110, 5'b01_111:
        exp_inst = {bimm[12], bimm[10:5], 5'd0, rs1p, 2'b00, c[13], bimm[4:1], bimm[11], 7'b1100011};
      5'b10_000: begin
        if (c[12]) exp_ill = 1'b1;
        else exp_inst = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011};
      end
      5'b10_010: begin
        if (rd == 5'd0) exp_ill = 1'b1;
        else exp_inst = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 != 5'd0)     exp_inst = {7'b0, rs2, 5'd0, 3'b000, rd, 7'b0110011};
          else if (rd == 5'd0) exp_ill  = 1'b1;
          else                 exp_inst = {12'b0, rd, 3'b000, 5'd0, 7'b1100111};
        end else begin
          if (rs2 != 5'd0)     exp_inst = {7'b0, rs2, rd, 3'b000, rd, 7'b0110011};
          else if (rd == 5'd0) exp_inst = 32'h0010_0073;
          else                 exp_inst = {12'b0, rd, 3'b000, 5'd1, 7'b1100111};
        end
      end
      5'b10_110: exp_inst = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
      default:   exp_ill = 1'b1;
    endcase
  end

  // Parcel storage; fetch_ready already guarantees room for two parcels.
  always_ff @(posedge clk_in) begin
    if (push_en) begin
      if (drop_lo) begin
        buf_q[wr_ptr] <= fetch_data[31:16];
      end else begin
        buf_q[wr_ptr]             <= fetch_data[15:0];
        buf_q[ptr_add(wr_ptr, 1)] <= fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_pc  <= RESET_PC;
      exp_word <= RESET_PC[ADDR_WIDTH-1:2];
      drop_lo  <= RESET_PC[1];
    end else if (rdy_in) begin
      if (flush_in) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        head_pc  <= {flush_pc[ADDR_WIDTH-1:1], 1'b0};
        exp_word <= flush_pc[ADDR_WIDTH-1:2];
        drop_lo  <= flush_pc[1];
      end else begin
        rd_ptr  <= ptr_add(rd_ptr, 32'(pop_n));
        wr_ptr  <= ptr_add(wr_ptr, 32'(push_n));
        count   <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        head_pc <= head_pc + ADDR_WIDTH'({pop_n, 1'b0});
        if (push_en) begin
          exp_word <= exp_word + WRD_W'(1);
          drop_lo  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_aligner.sv
// Bench for inst_aligner: directed test-plan scenarios plus a randomized run
// checked against a program-image model of the fetch stream.
module tb_inst_aligner;

  localparam int unsigned NB = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic [31:0] flush_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_addr, fetch_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        inst_is_c, inst_illegal;

  always #5 clk_in = ~clk_in;

  inst_aligner #(.ADDR_WIDTH(32), .BUF_PARCELS(NB), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_is_c(inst_is_c), .inst_illegal(inst_illegal)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model: RVC expansion from field tables ----------------
  function automatic int fld(input logic [15:0] c, input int hi, input int lo);
    return int'((32'(c) >> lo) & ((32'd1 << (hi - lo + 1)) - 1));
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] i = imm;
    return {i[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] i = imm;
    return {i[11:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int f3);
    logic [31:0] i = imm;
    return {i[12], i[10:5], 5'd0, 5'(rs1), 3'(f3), i[4:1], i[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] i = imm;
    return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd);
    logic [31:0] i = imm20;
    return {i[19:0], 5'(rd), 7'h37};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic void ref_expand(input logic [15:0] c, output logic [31:0] ins, output logic ill);
    int rd, rs2, rdp, rs1p, u6, s6, v, sel;
    rd   = fld(c, 11, 7);
    rs2  = fld(c, 6, 2);
    rdp  = 8 + fld(c, 4, 2);
    rs1p = 8 + fld(c, 9, 7);
    u6   = fld(c, 12, 12) * 32 + fld(c, 6, 2);
    s6   = (u6 >= 32) ? u6 - 64 : u6;
    sel  = fld(c, 1, 0) * 8 + fld(c, 15, 13);
    ins  = '0;
    ill  = 1'b0;
    case (sel)
      0: begin
        v = fld(c, 12, 11) * 16 + fld(c, 10, 7) * 64 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 8;
        if (v == 0) ill = 1'b1; else ins = enc_i(v, 2, 0, rdp, 'h13);
      end
      2: ins = enc_i(fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64, rs1p, 2, rdp, 'h03);
      6: ins = enc_s(fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64, rdp, rs1p, 2);
      8: ins = enc_i(s6, rd, 0, rd, 'h13);
      9, 13: begin
        v = fld(c, 12, 12) * 2048 + fld(c, 11, 11) * 16 + fld(c, 10, 9) * 256 + fld(c, 8, 8) * 1024
          + fld(c, 7, 7) * 64 + fld(c, 6, 6) * 128 + fld(c, 5, 3) * 2 + fld(c, 2, 2) * 32;
        if (v >= 2048) v -= 4096;
        ins = enc_j(v, (sel == 9) ? 1 : 0);
      end
      10: ins = enc_i(s6, 0, 0, rd, 'h13);
      11: begin
        if (rd == 2) begin
          v = fld(c, 12, 12) * 512 + fld(c, 6, 6) * 16 + fld(c, 5, 5) * 64 + fld(c, 4, 3) * 128 + fld(c, 2, 2) * 32;
          if (v >= 512) v -= 1024;
          if (v == 0) ill = 1'b1; else ins = enc_i(v, 2, 0, 2, 'h13);
        end else begin
          if (u6 == 0) ill = 1'b1; else ins = enc_u(s6, rd);
        end
      end
      12: begin
        case (fld(c, 11, 10))
          0, 1: if (u6 >= 32) ill = 1'b1;
                else ins = enc_r(fld(c, 10, 10) * 32, rs2, rs1p, 5, rs1p, 'h13);
          2: ins = enc_i(s6, rs1p, 7, rs1p, 'h13);
          default: begin
            if (u6 >= 32) ill = 1'b1;
            else case (fld(c, 6, 5))
              0: ins = enc_r(32, rdp, rs1p, 0, rs1p, 'h33);
              1: ins = enc_r(0, rdp, rs1p, 4, rs1p, 'h33);
              2: ins = enc_r(0, rdp, rs1p, 6, rs1p, 'h33);
              default: ins = enc_r(0, rdp, rs1p, 7, rs1p, 'h33);
            endcase
          end
        endcase
      end
      14, 15: begin
        v = fld(c, 12, 12) * 256 + fld(c, 11, 10) * 8 + fld(c, 6, 5) * 64 + fld(c, 4, 3) * 2 + fld(c, 2, 2) * 32;
        if (v >= 256) v -= 512;
        ins = enc_b(v, rs1p, (sel == 15) ? 1 : 0);
      end
      16: if (u6 >= 32) ill = 1'b1; else ins = enc_r(0, rs2, rd, 1, rd, 'h13);
      18: if (rd == 0) ill = 1'b1;
          else ins = enc_i(fld(c, 12, 12) * 32 + fld(c, 6, 4) * 4 + fld(c, 3, 2) * 64, 2, 2, rd, 'h03);
      20: begin
        if (u6 < 32) begin
          if (rs2 != 0)     ins = enc_r(0, rs2, 0, 0, rd, 'h33);
          else if (rd == 0) ill = 1'b1;
          else              ins = enc_i(0, rd, 0, 0, 'h67);
        end else begin
          if (rs2 != 0)     ins = enc_r(0, rs2, rd, 0, rd, 'h33);
          else if (rd == 0) ins = 32'h0010_0073;
          else              ins = enc_i(0, rd, 0, 1, 'h67);
        end
      end
      22: ins = enc_s(fld(c, 12, 9) * 4 + fld(c, 8, 7) * 64, rs2, 2, 2);
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    return mem[a[8:1]];
  endfunction

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    fetch_valid = 1'b1; fetch_addr = a; fetch_data = d;
    #1 chk("push_ready", 32'(fetch_ready), 32'd1);
    step();
    fetch_valid = 1'b0;
    #1;
  endtask

  task automatic take(input string nm, input logic [31:0] pc, input logic [31:0] ins, input logic isc, input logic ill);
    chk({nm, "_valid"}, 32'(inst_valid), 32'd1);
    chk({nm, "_pc"}, inst_pc, pc);
    chk({nm, "_out"}, inst_out, ins);
    chk({nm, "_flags"}, 32'({inst_is_c, inst_illegal}), 32'({isc, ill}));
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    #1;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush_in = 1'b1; flush_pc = pc;
    #1;
    chk("flush_fr", 32'(fetch_ready), 32'd0);
    chk("flush_iv", 32'(inst_valid), 32'd0);
    step();
    flush_in = 1'b0;
    #1;
  endtask

  // ---------------- main ----------------
  logic [31:0] e_ins, wa, p_exp, hpc, ew;
  logic        e_ill, drop, fr_e, iv_e;
  logic [15:0] p0, p1;
  int          cnt, need, pop, pushn;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);

    // pin the reference expander with hand-decoded encodings
    ref_expand(16'h4501, e_ins, e_ill); chk("ref_c_li", e_ins, 32'h0000_0513);
    ref_expand(16'h9002, e_ins, e_ill); chk("ref_ebreak", e_ins, 32'h0010_0073);
    ref_expand(16'h0000, e_ins, e_ill); chk("ref_zero_ill", 32'(e_ill), 32'd1);
    ref_expand(16'hBFFD, e_ins, e_ill); chk("ref_c_j", e_ins, 32'hFFFF_F06F);
    ref_expand(16'h852E, e_ins, e_ill); chk("ref_c_mv", e_ins, 32'h00B0_0533);
    ref_expand(16'h4188, e_ins, e_ill); chk("ref_c_lw", e_ins, 32'h0005_A503);

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; flush_pc = '0;
    fetch_valid = 1'b0; fetch_addr = '0; fetch_data = '0; inst_ready = 1'b0;
    step(); step();
    chk("rst_fr", 32'(fetch_ready), 32'd0);
    chk("rst_iv", 32'(inst_valid), 32'd0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_out", inst_out, 32'h0);
    chk("rst_flags", 32'({inst_is_c, inst_illegal}), 32'd0);
    rst_in = 1'b0;
    #1 chk("post_rst_fr", 32'(fetch_ready), 32'd1);

    push(32'h0, 32'h0000_0513);
    push(32'h4, 32'h00A0_0593);
    take("w32_a", 32'h0, 32'h0000_0513, 1'b0, 1'b0);
    take("w32_b", 32'h4, 32'h00A0_0593, 1'b0, 1'b0);
    chk("empty_iv", 32'(inst_valid), 32'd0);

    flush_to(32'h0);
    push(32'h0, 32'h4501_4501);
    take("cc_a", 32'h0, 32'h0000_0513, 1'b1, 1'b0);
    take("cc_b", 32'h2, 32'h0000_0513, 1'b1, 1'b0);

    flush_to(32'h0);
    push(32'h0, 32'h0513_4501);
    take("str_a", 32'h0, 32'h0000_0513, 1'b1, 1'b0);
    chk("str_wait_iv", 32'(inst_valid), 32'd0);
    push(32'h4, 32'h4501_0000);
    take("str_b", 32'h2, 32'h0000_0513, 1'b0, 1'b0);
    take("str_c", 32'h6, 32'h0000_0513, 1'b1, 1'b0);

    push(32'h8, 32'h9002_0000);
    take("ill0", 32'h8, 32'h0, 1'b1, 1'b1);
    take("ebrk", 32'hA, 32'h0010_0073, 1'b1, 1'b0);

    push(32'hC, 32'h852E_4188);
    push(32'h10, 32'h00A0_0593);
    fetch_valid = 1'b1; fetch_addr = 32'h14; fetch_data = 32'hBFFD_4501;
    #1 chk("full_fr", 32'(fetch_ready), 32'd0);
    step();
    fetch_valid = 1'b0;
    take("bp_lw", 32'hC, 32'h0005_A503, 1'b1, 1'b0);
    take("bp_mv", 32'hE, 32'h00B0_0533, 1'b1, 1'b0);
    take("bp_w32", 32'h10, 32'h00A0_0593, 1'b0, 1'b0);
    chk("bp_empty_iv", 32'(inst_valid), 32'd0);
    push(32'h14, 32'hBFFD_4501);
    take("bp_li", 32'h14, 32'h0000_0513, 1'b1, 1'b0);
    take("bp_j", 32'h16, 32'hFFFF_F06F, 1'b1, 1'b0);

    push(32'h18, 32'h0000_0013);
    push(32'h1C, 32'h0000_0013);
    chk("fill_fr", 32'(fetch_ready), 32'd0);
    flush_to(32'h102);
    fetch_valid = 1'b1; fetch_addr = 32'hF8; fetch_data = 32'h4501_4501;
    #1 chk("stale_fr", 32'(fetch_ready), 32'd1);
    step();
    fetch_valid = 1'b0;
    #1 chk("stale_iv", 32'(inst_valid), 32'd0);
    push(32'h100, 32'h4501_1234);
    take("fl_li", 32'h102, 32'h0000_0513, 1'b1, 1'b0);
    chk("fl_empty_iv", 32'(inst_valid), 32'd0);

    // randomized phase against the program-image model
    hpc = 32'h104; ew = 32'h104; drop = 1'b0; cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 49) == 0);
      flush_pc    = $urandom;
      fetch_valid = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 2) != 0);
      wa          = ($urandom_range(0, 7) == 0) ? ew - 32'(4 * $urandom_range(1, 3)) : ew;
      fetch_addr  = wa | 32'($urandom_range(0, 3));
      fetch_data  = {hw(wa + 32'd2), hw(wa)};
      #1;
      p0   = hw(hpc);
      p1   = hw(hpc + 32'd2);
      need = (p0[1:0] == 2'b11) ? 2 : 1;
      fr_e = rdy_in && !flush_in && (cnt <= int'(NB) - 2);
      iv_e = rdy_in && !flush_in && (cnt >= need);
      chk("rnd_fr", 32'(fetch_ready), 32'(fr_e));
      chk("rnd_iv", 32'(inst_valid), 32'(iv_e));
      chk("rnd_pc", inst_pc, hpc);
      if (iv_e) begin
        if (need == 2) begin
          p_exp = {p1, p0};
          chk("rnd_out32", inst_out, p_exp);
          chk("rnd_flags32", 32'({inst_is_c, inst_illegal}), 32'd0);
        end else begin
          ref_expand(p0, e_ins, e_ill);
          chk("rnd_out16", inst_out, e_ill ? 32'd0 : e_ins);
          chk("rnd_flags16", 32'({inst_is_c, inst_illegal}), 32'({1'b1, e_ill}));
        end
      end else begin
        chk("rnd_idle_out", inst_out, 32'd0);
        chk("rnd_idle_flags", 32'({inst_is_c, inst_illegal}), 32'd0);
      end
      if (rdy_in) begin
        if (flush_in) begin
          cnt = 0; hpc = flush_pc & ~32'd1; ew = flush_pc & ~32'd3; drop = flush_pc[1];
        end else begin
          pop   = (iv_e && inst_ready) ? need : 0;
          pushn = (fetch_valid && fr_e && (fetch_addr[31:2] == ew[31:2])) ? (drop ? 1 : 2) : 0;
          cnt   = cnt + pushn - pop;
          hpc   = hpc + 32'(2 * pop);
          if (pushn != 0) begin
            ew   = ew + 32'd4;
            drop = 1'b0;
          end
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
